tagger_readout: RTL and testbench

Reader for the 32-bit tag word stream that the time-tagger core writes into its output FIFO. Pops words from the FIFO read port, decodes tag and marker words, extends each tag's 27-bit time to a 64-bit absolute timestamp via a rollover epoch counter, and hands decoded events to the host-side transfer logic over a valid/ready interface. Sits between the tag FIFO and the host pipe.

---
 rtl/tagger_pkg.sv | 20 ++
 rtl/tagger_readout_buffer.sv | 44 ++++
 rtl/tagger_readout.sv | 120 ++++++++++++
 tb/tb_tagger_readout.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tagger_pkg.sv
// Shared word-format constants and event record for the time-tagger readout path.
package tagger_pkg;

    localparam int TIME_BITS_DEF    = 27;
    localparam int CHANNEL_BITS_DEF = 4;
    localparam int EPOCH_BITS_DEF   = 37;
    localparam int STAMP_BITS       = TIME_BITS_DEF + EPOCH_BITS_DEF;

    localparam int TAG_TYPE_BIT   = 31;
    localparam int MARKER_OVF_BIT = 30;
    localparam int CHANNEL_LSB    = 27;
    localparam int TIME_LSB       = 0;

    typedef struct packed {
        logic [CHANNEL_BITS_DEF-1:0] channel;
        logic [STAMP_BITS-1:0]       stamp;
        logic                        overflow;
    } event_t;

endpackage

// File: rtl/tagger_readout_buffer.sv
// Two-entry event FIFO between the decoder and the host handshake.
// Push while full is ignored unless a pop frees the slot in the same cycle.
module tagger_readout_buffer
    import tagger_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  event_t     push_data,
    input  logic       pop,
    output event_t     head,
    output logic [1:0] count
);

    event_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/tagger_readout.sv
// Tag FIFO reader: decodes tag/marker words, extends time with a rollover epoch,
// and presents events on valid/ready. Optional counters under TAGGER_READOUT_STATS_EN.
module tagger_readout
    import tagger_pkg::*;
#(
    parameter int TIME_BITS    = TIME_BITS_DEF,
    parameter int CHANNEL_BITS = CHANNEL_BITS_DEF,
    parameter int EPOCH_BITS   = EPOCH_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            read_empty,
    output logic                            read_enable,
    input  logic [31:0]                     read_data,
    input  logic [(1<<CHANNEL_BITS)-1:0]    conf_enable_channel,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNEL_BITS-1:0]         out_channel,
    output logic [TIME_BITS+EPOCH_BITS-1:0] out_time,
    output logic                            out_overflow,
    output logic [15:0]                     stat_overflows,
    output logic [31:0]                     stat_tags
);

    localparam logic [EPOCH_BITS-1:0] EPOCH_ONE = {{(EPOCH_BITS-1){1'b0}}, 1'b1};

    logic                    inflight;
    logic [EPOCH_BITS-1:0]   epoch;
    logic                    pending_overflow;
    logic [1:0]              buf_count;
    logic                    buf_push;
    logic                    pop;
    event_t                  buf_data;
    event_t                  buf_head;
    logic                    is_marker;
    logic                    is_ovf;
    logic                    tag_enabled;
    logic [CHANNEL_BITS-1:0] word_channel;
    logic [2:0]              occupancy;

    assign pop       = out_valid && out_ready;
    assign out_valid = (buf_count != 2'd0);

    // A pop this cycle frees a slot before the requested word can land, so it
    // counts as space already; this is what keeps one word per cycle streaming.
    assign occupancy   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign read_enable = rst_n && !read_empty && (occupancy < 3'd2);

    assign is_marker    = read_data[TAG_TYPE_BIT];
    assign is_ovf       = read_data[MARKER_OVF_BIT];
    assign word_channel = read_data[CHANNEL_LSB +: CHANNEL_BITS];
    assign tag_enabled  = conf_enable_channel[word_channel];
    assign buf_push     = inflight && !is_marker && tag_enabled;

    always_comb begin
        buf_data          = '0;
        buf_data.channel  = word_channel;
        buf_data.stamp    = {epoch, read_data[TIME_LSB +: TIME_BITS]};
        buf_data.overflow = pending_overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight         <= 1'b0;
            epoch            <= '0;
            pending_overflow <= 1'b0;
        end else begin
            inflight <= read_enable;
            if (inflight && is_marker) begin
                if (is_ovf) begin
                    pending_overflow <= 1'b1;
                end else begin
                    epoch <= epoch + EPOCH_ONE;
                end
            end else if (buf_push) begin
                pending_overflow <= 1'b0;
            end
        end
    end

    tagger_readout_buffer u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (buf_data),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign out_channel  = buf_head.channel;
    assign out_time     = buf_head.stamp;
    assign out_overflow = buf_head.overflow;

`ifdef TAGGER_READOUT_STATS_EN
    logic [15:0] ovf_count;
    logic [31:0] tag_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= 16'd0;
            tag_count <= 32'd0;
        end else begin
            if (inflight && is_marker && is_ovf && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
            if (pop) begin
                tag_count <= tag_count + 32'd1;
            end
        end
    end

    assign stat_overflows = ovf_count;
    assign stat_tags      = tag_count;
`else
    assign stat_overflows = 16'd0;
    assign stat_tags      = 32'd0;
`endif

endmodule

// File: tb/tb_tagger_readout.sv
// Bench for tagger_readout: FIFO model, event scoreboard, stimulus table and corner sequences.
module tb_tagger_readout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_empty = 1'b1;
    logic        read_enable;
    logic [31:0] read_data = 32'd0;
    logic [15:0] conf_enable_channel;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_channel;
    logic [63:0] out_time;
    logic        out_overflow;
    logic [15:0] stat_overflows;
    logic [31:0] stat_tags;

    always #5 clk = ~clk;

    tagger_readout dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .read_empty          (read_empty),
        .read_enable         (read_enable),
        .read_data           (read_data),
        .conf_enable_channel (conf_enable_channel),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_channel         (out_channel),
        .out_time            (out_time),
        .out_overflow        (out_overflow),
        .stat_overflows      (stat_overflows),
        .stat_tags           (stat_tags)
    );

    typedef struct packed {
        logic [3:0]  ch;
        logic [63:0] t;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic        emit;
        logic [3:0]  ch;
        logic [63:0] t;
        logic        ovf;
    } vec_t;

    exp_t        exp_q [$];
    logic [31:0] fifo_q [$];
    exp_t        mon_e;
    logic        pop_now;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic expect_ev(input logic [3:0] ch, input logic [63:0] t, input logic ovf);
        exp_q.push_back('{ch, t, ovf});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid || fifo_q.size() != 0) && cyc < 300) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        n_cmp++;
        if (cyc >= 300 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d events still expected after %0d cycles, required 0", name, exp_q.size(), cyc);
        end
    endtask

    // FIFO read port: data appears one cycle after read_enable
    always begin
        @(posedge clk);
        pop_now = read_enable && rst_n;
        #1;
        if (pop_now && fifo_q.size() != 0) read_data = fifo_q.pop_front();
        read_empty = (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got ch%0d time 0x%0h, required no event", out_channel, out_time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ev_channel", {60'd0, out_channel}, {60'd0, mon_e.ch});
                check("ev_time", out_time, mon_e.t);
                check("ev_overflow", {63'd0, out_overflow}, {63'd0, mon_e.ovf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   cyc;
        int   lat;
        int   nreads;
        int   unstable;
        logic [15:0] exp_ovf_stat;

        vecs[0] = '{32'h8000_0000, 1'b0, 4'd0, 64'h0, 1'b0};
        vecs[1] = '{32'h0800_0003, 1'b1, 4'd1, 64'h0000_0000_0800_0003, 1'b0};
        vecs[2] = '{32'hC000_0000, 1'b0, 4'd0, 64'h0, 1'b0};
        vecs[3] = '{32'h1000_0010, 1'b1, 4'd2, 64'h0000_0000_0800_0010, 1'b1};
        vecs[4] = '{32'h1000_0011, 1'b1, 4'd2, 64'h0000_0000_0800_0011, 1'b0};

        rst_n = 1'b0;
        out_ready = 1'b0;
        conf_enable_channel = 16'hFFFF;
        tick();
        tick();
        check("rst_read_enable", {63'd0, read_enable}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_channel", {60'd0, out_channel}, 64'd0);
        check("rst_out_time", out_time, 64'd0);
        check("rst_out_overflow", {63'd0, out_overflow}, 64'd0);
        check("rst_stat_tags", {32'd0, stat_tags}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // first-word latency
        push_word(32'h0800_0005);
        expect_ev(4'd1, 64'h5, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!read_enable && cyc < 10);
        check("first_read_enable", {63'd0, read_enable}, 64'd1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_latency", lat, 64'd2);
        tick();

        for (int i = 0; i < 5; i++) begin
            push_word(vecs[i].word);
            if (vecs[i].emit) expect_ev(vecs[i].ch, vecs[i].t, vecs[i].ovf);
        end
        drain("table");
`ifdef TAGGER_READOUT_STATS_EN
        check("stat_overflows_1", {48'd0, stat_overflows}, 64'd1);
        check("stat_tags_1", {32'd0, stat_tags}, 64'd4);
`else
        check("stat_overflows_1", {48'd0, stat_overflows}, 64'd0);
        check("stat_tags_1", {32'd0, stat_tags}, 64'd0);
`endif

        // disabled channel keeps overflow pending for the next emitted tag
        conf_enable_channel = 16'hFFFD;
        push_word(32'hC000_0000);
        push_word(32'h0800_0007);
        push_word(32'h0000_0009);
        push_word(32'h0000_0004);
        expect_ev(4'd0, 64'h0800_0009, 1'b1);
        expect_ev(4'd0, 64'h0800_0004, 1'b0);
        drain("chan_mask");
        conf_enable_channel = 16'hFFFF;
`ifdef TAGGER_READOUT_STATS_EN
        exp_ovf_stat = 16'd2;
`else
        exp_ovf_stat = 16'd0;
`endif
        check("stat_overflows_2", {48'd0, stat_overflows}, {48'd0, exp_ovf_stat});

        // backpressure: only two reads while stalled, head held steady
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [3:0]  ch;
            logic [26:0] t;
            ch = 4'(i);
            t  = 27'(100 + i);
            push_word({1'b0, ch, t});
            expect_ev(ch, {37'd1, t}, 1'b0);
        end
        nreads = 0;
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (read_enable) nreads++;
            if (c >= 5 && (!out_valid || out_channel != 4'd0 || out_time != 64'h0800_0064 || out_overflow))
                unstable++;
        end
        check("stall_reads", nreads, 64'd2);
        check("stall_unstable_cycles", unstable, 64'd0);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        tick();
        out_ready = 1'b1;
        drain("backpressure");

        // epoch wrap at 2^37
        force dut.epoch = {37{1'b1}};
        tick();
        release dut.epoch;
        push_word(32'h2000_0001);
        push_word(32'h8000_0000);
        push_word(32'h1800_0123);
        expect_ev(4'd4, 64'hFFFF_FFFF_F800_0001, 1'b0);
        expect_ev(4'd3, 64'h0000_0000_0000_0123, 1'b0);
        drain("epoch_wrap");
        check("epoch_after_wrap", {27'd0, dut.epoch}, 64'd0);

        // asynchronous reset while holding events
        push_word(32'h8000_0000);
        tick();
        out_ready = 1'b0;
        push_word(32'h0800_0001);
        push_word(32'h0800_0002);
        push_word(32'h0800_0003);
        for (int c = 0; c < 8; c++) tick();
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_out_time", out_time, 64'd0);
        check("async_epoch", {27'd0, dut.epoch}, 64'd0);
        check("async_read_enable", {63'd0, read_enable}, 64'd0);
        check("async_stat_overflows", {48'd0, stat_overflows}, 64'd0);
        check("async_stat_tags", {32'd0, stat_tags}, 64'd0);
        fifo_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        push_word(32'h0800_0005);
        expect_ev(4'd1, 64'h5, 1'b0);
        drain("after_reset");
`ifdef TAGGER_READOUT_STATS_EN
        check("stat_tags_end", {32'd0, stat_tags}, 64'd1);
`else
        check("stat_tags_end", {32'd0, stat_tags}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
